stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Key-driven sequencer for the digital stopwatch datapath. Debounces the three front-panel keys (start/stop, pause, load), runs the stopwatch state machine, and drives the counter's clear, enable and load controls. Sits between the raw key pins and the 1 kHz watch counter; all outputs are registered in the 50 MHz domain.

## Interface
- CLK_HZ, 50_000_000, input clock frequency
- TICK_HZ, 1000, debounce sample-tick rate
- DEBOUNCE_MS, 20, consecutive stable ticks required to accept a key level
- clk_50Mhz  input  1  system clock
- rst_n  input  1  asynchronous, active-low reset
- key_start  input  1  raw start/stop key, active-low (pressed = 0), asynchronous
- key_pause  input  1  raw pause key, active-low, asynchronous
- key_load  input  1  raw preset-load key, active-low, asynchronous
- cnt_clr  output  1  one-cycle clear pulse to counter
- cnt_en  output  1  counter enable level
- cnt_load  output  1  one-cycle preset-load pulse to counter
- disp_hold  output  1  display freeze level (lap), 0 when LAP_EN absent
- state  output  2  current FSM state, encoding from package

## Operation
- Each key: 2-flop synchronizer, then debouncer sampling on a shared tick (every CLK_HZ/TICK_HZ cycles). Debounced level changes only after DEBOUNCE_MS consecutive ticks at the new level; any disagreeing sample restarts the count.
- Press event: single-cycle pulse on debounced 1->0 transition. Releases generate nothing. Holding a key produces exactly one event.
- States: IDLE (cleared, stopped), RUN, PAUSE, STOP (halted, value held).
- IDLE: start -> RUN; load -> stay IDLE, pulse cnt_load.
- RUN: start -> STOP; pause -> PAUSE.
- PAUSE: pause -> RUN; start -> STOP.
- STOP: start -> IDLE with cnt_clr pulse; load -> stay STOP, pulse cnt_load.
- Unlisted events in a state are ignored.
- cnt_en = 1 only in RUN.
- Simultaneous events in one cycle: priority start > pause > load; lower-priority events that cycle are discarded.
- Reset: state IDLE, cnt_en 0, cnt_load 0, disp_hold 0, cnt_clr 1 (held during reset, deasserts on the first clock after rst_n rises), debouncers at released level with counts cleared, tick prescaler cleared.
- Reset mid-debounce or mid-run: everything returns to reset values; no event generated on release of rst_n even if a key is held (debounced level starts released, so a held key produces an event only after DEBOUNCE_MS ticks).

## Timing
- Synchronizer: 2 cycles. Debounce: DEBOUNCE_MS ticks from last change, ± one tick.
- Event pulse: 1 cycle after debounced level change.
- FSM/outputs registered: cnt_en, cnt_clr, cnt_load, state update on the clock edge after the event cycle (1-cycle event-to-output latency).
- cnt_clr and cnt_load are exactly one cycle wide (except reset hold of cnt_clr).
- Prescaler count width ceil(log2(CLK_HZ/TICK_HZ)); debounce count width ceil(log2(DEBOUNCE_MS+1)); counts saturate, never wrap.

## Configuration
- LAP_EN defined: in RUN, pause key instead toggles disp_hold (counter keeps running, cnt_en stays 1); PAUSE state unreachable. disp_hold cleared on any exit from RUN and on reset.
- LAP_EN undefined: pause behaves as above (RUN<->PAUSE); disp_hold tied to 0.

## Structure
- Package watch_pkg: state enum (IDLE=0, RUN=1, PAUSE=2, STOP=3), default tick/debounce constants.
- Sub-module key_debounce (synchronizer + stable counter + press-event output), instantiated three times; tick prescaler and FSM in stopwatch_ctrl.

## Test plan
Bench parameters CLK_HZ=1000, TICK_HZ=100 (10-cycle tick), DEBOUNCE_MS=3.
- Reset then idle: cnt_clr=1 during reset, 0 one cycle after; state=IDLE, cnt_en=0.
- Clean start press held 100 cycles -> one event, state RUN, cnt_en=1 within 32-45 cycles of press; release generates nothing.
- Bouncing start (toggle every 5 cycles for 40 cycles, then steady low) -> exactly one event, timed from last edge.
- Sequence start, pause, pause, start, start -> RUN, PAUSE, RUN, STOP, IDLE with one-cycle cnt_clr on last step; cnt_en matches RUN only.
- Load in IDLE and STOP -> one-cycle cnt_load, state unchanged; load in RUN -> ignored. Start and load debounced in same cycle in IDLE -> RUN, no cnt_load.
- LAP_EN build: RUN + pause -> disp_hold=1, cnt_en=1; pause again -> 0; start -> STOP, disp_hold=0.

Source files
------------

// File: rtl/watch_pkg.sv
// watch_pkg: state encoding, default timing constants and width helper for the stopwatch controller
package watch_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    STOP  = 2'd3
  } state_t;
  localparam int DEF_CLK_HZ = 50_000_000;
  localparam int DEF_TICK_HZ = 1000;
  localparam int DEF_DEBOUNCE_MS = 20;
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/stopwatch_ctrl_if.sv
// stopwatch_ctrl_if: counter control bundle from the key sequencer to the watch counter
interface stopwatch_ctrl_if;
  import watch_pkg::*;
  logic   cnt_clr;
  logic   cnt_en;
  logic   cnt_load;
  logic   disp_hold;
  state_t state;
  modport master(output cnt_clr, cnt_en, cnt_load, disp_hold, state);
  modport slave(input cnt_clr, cnt_en, cnt_load, disp_hold, state);
endinterface

// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchronizer, tick-sampled stable counter and single-cycle press event for one active-low key
module key_debounce
  import watch_pkg::*;
#(
  parameter int DEBOUNCE_MS = DEF_DEBOUNCE_MS
) (
  input  logic clk_50Mhz,
  input  logic rst_n,
  input  logic key_n_i,
  input  logic tick_i,
  output logic press_o
);
  localparam int CW = cw(DEBOUNCE_MS + 1);
  logic [1:0]    sync_q;
  logic          lvl_q, lvl_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          press_q;
  logic          agree, done;
  assign agree = sync_q[1] == lvl_q;
  assign done  = cnt_q == CW'(DEBOUNCE_MS);
  // count disagreeing samples; any agreeing sample restarts, and the count stops at the limit
  always_comb begin
    lvl_d = (tick_i && !agree && done) ? sync_q[1] : lvl_q;
    cnt_d = !tick_i ? cnt_q : (agree || done) ? '0 : cnt_q + 1'b1;
  end
  // start released so a key held through reset needs a full debounce before its event
  always_ff @(posedge clk_50Mhz or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      lvl_q   <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], key_n_i};
      lvl_q   <= lvl_d;
      cnt_q   <= cnt_d;
      press_q <= lvl_q & ~lvl_d;
    end
  end
  assign press_o = press_q;
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: debounced three-key sequencer driving the watch counter; LAP_EN turns pause-in-RUN into a display hold toggle
module stopwatch_ctrl
  import watch_pkg::*;
#(
  parameter int CLK_HZ      = DEF_CLK_HZ,
  parameter int TICK_HZ     = DEF_TICK_HZ,
  parameter int DEBOUNCE_MS = DEF_DEBOUNCE_MS
) (
  input  logic clk_50Mhz,
  input  logic rst_n,
  input  logic key_start,
  input  logic key_pause,
  input  logic key_load,
  stopwatch_ctrl_if.master sw
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = cw(DIV);
  logic [PW-1:0] pre_q, pre_d;
  logic          tick;
  logic          s_ev, p_ev, l_ev;
  logic          ev_s, ev_p, ev_l;
  state_t        state_q;
  logic          en_q, clr_q, load_q, hold_q;
  assign tick  = pre_q == PW'(DIV - 1);
  assign pre_d = tick ? '0 : pre_q + 1'b1;
  // shared debounce sample tick
  always_ff @(posedge clk_50Mhz or negedge rst_n) begin
    if (!rst_n) pre_q <= '0;
    else        pre_q <= pre_d;
  end
  key_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_start (
    .clk_50Mhz(clk_50Mhz), .rst_n(rst_n), .key_n_i(key_start), .tick_i(tick), .press_o(s_ev)
  );
  key_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_pause (
    .clk_50Mhz(clk_50Mhz), .rst_n(rst_n), .key_n_i(key_pause), .tick_i(tick), .press_o(p_ev)
  );
  key_debounce #(.DEBOUNCE_MS(DEBOUNCE_MS)) u_load (
    .clk_50Mhz(clk_50Mhz), .rst_n(rst_n), .key_n_i(key_load), .tick_i(tick), .press_o(l_ev)
  );
  // only the highest-priority event of a cycle survives: start > pause > load
  always_comb begin
    ev_s = s_ev;
    ev_p = p_ev & ~s_ev;
    ev_l = l_ev & ~s_ev & ~p_ev;
  end
  // stopwatch FSM with registered counter controls; clear is held while in reset
  always_ff @(posedge clk_50Mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      en_q    <= 1'b0;
      clr_q   <= 1'b1;
      load_q  <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      clr_q  <= 1'b0;
      load_q <= 1'b0;
      case (state_q)
        IDLE:
          if (ev_s) begin
            state_q <= RUN;
            en_q    <= 1'b1;
          end else if (ev_l) load_q <= 1'b1;
        RUN:
          if (ev_s) begin
            state_q <= STOP;
            en_q    <= 1'b0;
            hold_q  <= 1'b0;
          end
`ifdef LAP_EN
          else if (ev_p) hold_q <= ~hold_q;
`else
          else if (ev_p) begin
            state_q <= PAUSE;
            en_q    <= 1'b0;
          end
`endif
        PAUSE:
          if (ev_s) state_q <= STOP;
          else if (ev_p) begin
            state_q <= RUN;
            en_q    <= 1'b1;
          end
        STOP:
          if (ev_s) begin
            state_q <= IDLE;
            clr_q   <= 1'b1;
          end else if (ev_l) load_q <= 1'b1;
        default: begin
          state_q <= IDLE;
          en_q    <= 1'b0;
          hold_q  <= 1'b0;
        end
      endcase
    end
  end
  assign sw.state    = state_q;
  assign sw.cnt_en   = en_q;
  assign sw.cnt_clr  = clr_q;
  assign sw.cnt_load = load_q;
`ifdef LAP_EN
  assign sw.disp_hold = hold_q;
`else
  assign sw.disp_hold = 1'b0;
`endif
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: scoreboard bench; stimulus queues expected output changes, a monitor compares each change
module tb_stopwatch_ctrl;
  import watch_pkg::*;
  localparam logic [2:0] KS = 3'b001;
  localparam logic [2:0] KP = 3'b010;
  localparam logic [2:0] KL = 3'b100;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] keys_n = 3'b111;
  logic [5:0] obs;
  logic [5:0] exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         lat;
  always #5 clk = ~clk;
  stopwatch_ctrl_if swif();
  stopwatch_ctrl #(.CLK_HZ(1000), .TICK_HZ(100), .DEBOUNCE_MS(3)) dut (
    .clk_50Mhz(clk),
    .rst_n(rst_n),
    .key_start(keys_n[0]),
    .key_pause(keys_n[1]),
    .key_load(keys_n[2]),
    .sw(swif)
  );
  assign obs = {swif.state, swif.cnt_en, swif.cnt_clr, swif.cnt_load, swif.disp_hold};
  function automatic logic [5:0] o(state_t s, logic en, logic clr, logic ld, logic hd);
    return {s, en, clr, ld, hd};
  endfunction
  task automatic step();
    @(posedge clk);
    #2;
  endtask
  task automatic chk(string name, logic [5:0] act, logic [5:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got state/en/clr/load/hold=%b want %b", name, act, want);
    end
  endtask
  task automatic drain(string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s timeout: %0d expected output changes never seen, want 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (70) step();
  endtask
  task automatic press(string name, logic [2:0] m, int hold, output int l);
    l = -1;
    keys_n = ~m;
    for (int i = 1; i <= hold; i++) begin
      step();
      if (l < 0 && exp_q.size() == 0) l = i;
    end
    keys_n = 3'b111;
    drain(name);
  endtask
  task automatic lat_chk(string name, int l);
    checks++;
    if (l < 32 || l > 45) begin
      errors++;
      $display("FAIL %s latency got %0d cycles want 32..45", name, l);
    end
  endtask
  // monitor: every output change outside reset must match the head of the expected queue
  initial begin
    logic [5:0] prev;
    logic [5:0] e;
    prev = obs;
    forever begin
      @(negedge clk);
      if (rst_n && obs !== prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected output change got %b want no change from %b", obs, prev);
        end else begin
          e = exp_q.pop_front();
          chk("monitor", obs, e);
        end
      end
      prev = obs;
    end
  end
  initial begin
    repeat (3) step();
    chk("reset_hold", obs, o(IDLE, 0, 1, 0, 0));
    exp_q.push_back(o(IDLE, 0, 0, 0, 0));
    rst_n = 1'b1;
    step();
    chk("reset_release", obs, o(IDLE, 0, 0, 0, 0));
    repeat (20) step();
    exp_q.push_back(o(RUN, 1, 0, 0, 0));
    press("clean_start", KS, 100, lat);
    lat_chk("clean_start", lat);
    exp_q.push_back(o(STOP, 0, 0, 0, 0));
    for (int i = 0; i < 8; i++) begin
      keys_n[0] = i[0];
      repeat (5) step();
    end
    keys_n[0] = 1'b0;
    repeat (100) step();
    keys_n[0] = 1'b1;
    drain("bounce_start");
    exp_q.push_back(o(STOP, 0, 0, 1, 0));
    exp_q.push_back(o(STOP, 0, 0, 0, 0));
    press("load_stop", KL, 100, lat);
    exp_q.push_back(o(IDLE, 0, 1, 0, 0));
    exp_q.push_back(o(IDLE, 0, 0, 0, 0));
    press("start_stop_to_idle", KS, 100, lat);
    exp_q.push_back(o(IDLE, 0, 0, 1, 0));
    exp_q.push_back(o(IDLE, 0, 0, 0, 0));
    press("load_idle", KL, 100, lat);
    exp_q.push_back(o(RUN, 1, 0, 0, 0));
    press("start_idle", KS, 100, lat);
    press("load_run_ignored", KL, 100, lat);
`ifdef LAP_EN
    exp_q.push_back(o(RUN, 1, 0, 0, 1));
    press("lap_on", KP, 100, lat);
    exp_q.push_back(o(RUN, 1, 0, 0, 0));
    press("lap_off", KP, 100, lat);
    exp_q.push_back(o(RUN, 1, 0, 0, 1));
    press("lap_on_again", KP, 100, lat);
`else
    exp_q.push_back(o(PAUSE, 0, 0, 0, 0));
    press("pause", KP, 100, lat);
    exp_q.push_back(o(RUN, 1, 0, 0, 0));
    press("resume", KP, 100, lat);
    exp_q.push_back(o(PAUSE, 0, 0, 0, 0));
    press("pause_again", KP, 100, lat);
`endif
    exp_q.push_back(o(STOP, 0, 0, 0, 0));
    press("start_to_stop", KS, 100, lat);
    exp_q.push_back(o(IDLE, 0, 1, 0, 0));
    exp_q.push_back(o(IDLE, 0, 0, 0, 0));
    press("stop_clear", KS, 100, lat);
    exp_q.push_back(o(RUN, 1, 0, 0, 0));
    press("start_and_load", KS | KL, 100, lat);
    keys_n[0] = 1'b0;
    rst_n = 1'b0;
    repeat (5) step();
    chk("midrun_reset", obs, o(IDLE, 0, 1, 0, 0));
    exp_q.push_back(o(IDLE, 0, 0, 0, 0));
    exp_q.push_back(o(RUN, 1, 0, 0, 0));
    rst_n = 1'b1;
    press("held_through_reset", KS, 100, lat);
    lat_chk("held_through_reset", lat);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
